dcache_resp: RTL and testbench
==============================

DCACHE_RESP -- requirements
Module: dcache_resp

Interface
REQ-001 Parameter MISS_LAT, default 4, is the backing-memory access latency in cycles per writeback or refill; legal range 1..15.
REQ-002 clk  in  1  single clock; all state changes on its rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 dcache_raddr_i  in  32  byte read address.
REQ-005 dcache_rreq_i  in  1  read request, level; held by the initiator while dcache_stall_o is high.
REQ-006 dcache_waddr_i  in  32  byte write address.
REQ-007 dcache_wdata_i  in  32  write data.
REQ-008 dcache_wsel_i  in  4  byte enables; bit n covers wdata[8n+7:8n].
REQ-009 dcache_wreq_i  in  1  write request, level; held while dcache_stall_o is high.
REQ-010 dcache_data_o  out  32  read data, combinational.
REQ-011 dcache_stall_o  out  1  high while any asserted request cannot complete this cycle.

Function
REQ-012 Organisation: direct-mapped, write-back, write-allocate; 16 lines of 4 words; internal 1024-word backing memory.
REQ-013 Address split: offset = addr[3:2], index = addr[7:4], tag = addr[11:8]; addr[31:12] and addr[1:0] ignored.
REQ-014 Per line: valid bit, dirty bit, 4-bit tag and 4 data words.
REQ-015 FSM states: IDLE, WB, REFILL.
REQ-016 A request hits when its line is valid and its stored tag equals the address tag.
REQ-017 Read hit in IDLE: dcache_data_o = addressed word in the same cycle (zero-wait); dcache_stall_o low.
REQ-018 Write hit in IDLE: bytes selected by wsel are merged into the addressed word at the sampling edge; dirty is set; dcache_stall_o low.
REQ-019 wsel = 0000 with a write hit: no data change, no dirty set.
REQ-020 Same-cycle read and write hit to the same word: dcache_data_o returns the stored word merged with the enabled write bytes (forwarding).
REQ-021 With dcache_rreq_i low, dcache_data_o = 0.
REQ-022 Miss in IDLE: dcache_stall_o goes high combinationally in the same cycle.
REQ-023 Miss transition: at the next edge, go to WB if the victim is valid and dirty, else go to REFILL.
REQ-024 Simultaneous read and write requests with a miss: the write miss is serviced first, then the read miss; both requests see stall until both hit.
REQ-025 WB: count MISS_LAT cycles.
REQ-026 WB last cycle: copy all 4 victim words to the backing memory at the victim's tag/index, clear dirty, go to REFILL.
REQ-027 REFILL: count MISS_LAT cycles.
REQ-028 REFILL last cycle: load 4 words from the backing memory at the request tag/index, set valid, write tag, clear dirty, go to IDLE.
REQ-029 dcache_stall_o is high in every WB and REFILL cycle.
REQ-030 Stall lengths: clean miss = 1+MISS_LAT cycles; dirty miss = 1+2*MISS_LAT cycles; then one hit cycle with stall low.
REQ-031 Requests deasserted during WB/REFILL: the line transfer still completes; FSM then returns to IDLE.
REQ-032 Backing-memory line copies are atomic on the last counted cycle; no partial lines.

Reset
REQ-033 On rst: FSM = IDLE, latency counter = 0, all valid and dirty bits cleared; cache data and backing memory are not reset.
REQ-034 Reset during WB or REFILL abandons the operation; a WB that has not reached its last cycle writes nothing to the backing memory.
REQ-035 dcache_stall_o is low in the first cycle after reset when no request is asserted.

Configuration
REQ-036 With macro DCACHE_RESP_STATS_EN defined, two outputs are added: hit_cnt_o[31:0] and miss_cnt_o[31:0].
REQ-037 hit_cnt_o: +1 per port (read, write) per IDLE cycle in which that request hits.
REQ-038 miss_cnt_o: +1 per IDLE-to-WB or IDLE-to-REFILL transition.
REQ-039 Both counters saturate at 0xFFFFFFFF and reset to 0.
REQ-040 Without DCACHE_RESP_STATS_EN, these ports and counters do not exist and behaviour is otherwise identical.

Verification
REQ-041 After reset, read 0x010 with MISS_LAT=4 -> stall high for exactly 5 cycles, then data_o = backing word 0x004, stall low.
REQ-042 Write 0x0000BEEF to 0x020, wsel=1111, then read 0x020 on the next cycle -> data_o = 0x0000BEEF with stall low on the read cycle.
REQ-043 Word at 0x030 = 0x11223344; write 0xAABBCCDD with wsel=0101 -> read returns 0x11BB33DD; same-cycle read and write to that word returns the same merged value.
REQ-044 Dirty line at 0x040, then read 0x140 -> stall for 9 cycles; a later read of 0x040 shows backing memory holds the written data.
REQ-045 Assert rst in the 2nd WB cycle -> FSM IDLE next cycle, all lines invalid, backing word unchanged.
REQ-046 With DCACHE_RESP_STATS_EN: one clean miss followed by 3 read-hit cycles -> miss_cnt_o = 1, hit_cnt_o = 3.

Source files
------------

// File: rtl/dcache_resp.sv
// dcache_resp: direct-mapped, write-back, write-allocate data cache with a
// 1024-word internal backing memory. The cache has 16 lines of 4 words.
// Each writeback or refill takes MISS_LAT cycles, and the whole line moves
// on the last counted cycle.
// Optional build macro DCACHE_RESP_STATS_EN adds hit and miss counters
// (hit_cnt_o, miss_cnt_o).
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | serve hits; on a miss latch target and pick WB or REFILL
// S_WB     | count MISS_LAT cycles, then copy dirty victim to backing mem
// S_REFILL | count MISS_LAT cycles, then load the target line from backing
//
// When both ports miss, the write target is fetched first. A write that
// hits while the other port still stalls is merged immediately. The
// initiator holds the request, so merging it again later is harmless.
module dcache_resp #(
    parameter int MISS_LAT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] dcache_raddr_i,
    input  logic        dcache_rreq_i,
    input  logic [31:0] dcache_waddr_i,
    input  logic [31:0] dcache_wdata_i,
    input  logic [3:0]  dcache_wsel_i,
    input  logic        dcache_wreq_i,
    output logic [31:0] dcache_data_o,
    output logic        dcache_stall_o
`ifdef DCACHE_RESP_STATS_EN
    ,
    output logic [31:0] hit_cnt_o,
    output logic [31:0] miss_cnt_o
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WB,
        S_REFILL
    } state_t;

    localparam logic [3:0] LAT_M1 = 4'(MISS_LAT - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  miss_tag_q, miss_idx_q;
    logic        miss_ld, wb_fire, refill_fire, stall;

    logic [15:0] valid_q, dirty_q;
    logic [3:0]  tag_q [0:15];
    logic [31:0] data_q [0:63];
    logic [31:0] bmem [0:1024-1];

    logic [1:0]  r_off, w_off;
    logic [3:0]  r_idx, r_tag, w_idx, w_tag;
    logic        r_hit, w_hit, r_miss, w_miss, in_idle, wr_en, fwd;
    logic [31:0] r_word, w_word, w_merged;
    logic [3:0]  m_tag_sel, m_idx_sel;
    logic        victim_dirty;

    logic        unused_addr_bits;
    assign unused_addr_bits = ^{dcache_raddr_i[31:12], dcache_raddr_i[1:0],
                                dcache_waddr_i[31:12], dcache_waddr_i[1:0]};

    assign r_off = dcache_raddr_i[3:2];
    assign r_idx = dcache_raddr_i[7:4];
    assign r_tag = dcache_raddr_i[11:8];
    assign w_off = dcache_waddr_i[3:2];
    assign w_idx = dcache_waddr_i[7:4];
    assign w_tag = dcache_waddr_i[11:8];

    assign in_idle = (state_q == S_IDLE);
    assign r_hit   = valid_q[r_idx] && (tag_q[r_idx] == r_tag);
    assign w_hit   = valid_q[w_idx] && (tag_q[w_idx] == w_tag);
    assign r_miss  = dcache_rreq_i && !r_hit;
    assign w_miss  = dcache_wreq_i && !w_hit;

    assign r_word  = data_q[{r_idx, r_off}];
    assign w_word  = data_q[{w_idx, w_off}];

    // byte-lane merge of write data into the addressed word
    always_comb begin
        w_merged = w_word;
        for (int b = 0; b < 4; b++) begin
            if (dcache_wsel_i[b]) begin
                w_merged[8*b +: 8] = dcache_wdata_i[8*b +: 8];
            end
        end
    end

    assign wr_en = in_idle && dcache_wreq_i && w_hit && (dcache_wsel_i != 4'b0000);
    assign fwd   = dcache_wreq_i && w_hit &&
                   ({w_tag, w_idx, w_off} == {r_tag, r_idx, r_off});

    assign dcache_data_o = (dcache_rreq_i && in_idle && r_hit) ?
                           (fwd ? w_merged : r_word) : 32'h0;

    assign m_tag_sel    = w_miss ? w_tag : r_tag;
    assign m_idx_sel    = w_miss ? w_idx : r_idx;
    assign victim_dirty = valid_q[m_idx_sel] && dirty_q[m_idx_sel];

    // next-state, latency down-counter and transfer strobes
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        miss_ld     = 1'b0;
        wb_fire     = 1'b0;
        refill_fire = 1'b0;
        stall       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (w_miss || r_miss) begin
                    stall   = 1'b1;
                    miss_ld = 1'b1;
                    cnt_d   = LAT_M1;
                    state_d = victim_dirty ? S_WB : S_REFILL;
                end
            end
            S_WB: begin
                stall = 1'b1;
                if (cnt_q == 4'd0) begin
                    wb_fire = 1'b1;
                    cnt_d   = LAT_M1;
                    state_d = S_REFILL;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_REFILL: begin
                stall = 1'b1;
                if (cnt_q == 4'd0) begin
                    refill_fire = 1'b1;
                    state_d     = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign dcache_stall_o = stall;

    // state register and latency counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // capture the line being fetched when a miss is accepted
    always_ff @(posedge clk) begin
        if (miss_ld) begin
            miss_tag_q <= m_tag_sel;
            miss_idx_q <= m_idx_sel;
        end
    end

    // line valid and dirty bits
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            if (wr_en) begin
                dirty_q[w_idx] <= 1'b1;
            end
            if (wb_fire) begin
                dirty_q[miss_idx_q] <= 1'b0;
            end
            if (refill_fire) begin
                valid_q[miss_idx_q] <= 1'b1;
                dirty_q[miss_idx_q] <= 1'b0;
            end
        end
    end

    // cache data and tags: write-hit merge and whole-line refill
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (wr_en) begin
                data_q[{w_idx, w_off}] <= w_merged;
            end
            if (refill_fire) begin
                tag_q[miss_idx_q] <= miss_tag_q;
                for (int k = 0; k < 4; k++) begin
                    data_q[{miss_idx_q, 2'(k)}] <= bmem[{miss_tag_q, miss_idx_q, 2'(k)}];
                end
            end
        end
    end

    // backing memory takes the whole victim line on the last WB cycle
    always_ff @(posedge clk) begin
        if (!rst && wb_fire) begin
            for (int k = 0; k < 4; k++) begin
                bmem[{tag_q[miss_idx_q], miss_idx_q, 2'(k)}] <= data_q[{miss_idx_q, 2'(k)}];
            end
        end
    end

`ifdef DCACHE_RESP_STATS_EN
    logic [1:0]  hit_inc;
    logic [32:0] hit_sum;
    logic [32:0] miss_sum;

    assign hit_inc  = 2'(in_idle && dcache_rreq_i && r_hit) +
                      2'(in_idle && dcache_wreq_i && w_hit);
    assign hit_sum  = {1'b0, hit_cnt_o} + 33'(hit_inc);
    assign miss_sum = {1'b0, miss_cnt_o} + 33'(miss_ld);

    // saturating hit/miss counters
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt_o  <= 32'h0;
            miss_cnt_o <= 32'h0;
        end else begin
            hit_cnt_o  <= hit_sum[32]  ? 32'hFFFF_FFFF : hit_sum[31:0];
            miss_cnt_o <= miss_sum[32] ? 32'hFFFF_FFFF : miss_sum[31:0];
        end
    end
`endif

endmodule

// File: tb/tb_dcache_resp.sv
// tb_dcache_resp: directed and randomized bench for dcache_resp.
// The reference keeps an architectural word view and a backing view of
// memory, and a per-line tag/valid/dirty record. Each access's stall length
// and read data are derived from those.
module tb_dcache_resp;

    localparam int L = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] raddr, waddr, wdata;
    logic        rreq, wreq;
    logic [3:0]  wsel;
    logic [31:0] data_o;
    logic        stall_o;
`ifdef DCACHE_RESP_STATS_EN
    logic [31:0] hit_cnt, miss_cnt;
`endif

    dcache_resp #(.MISS_LAT(L)) dut (
        .clk            (clk),
        .rst            (rst),
        .dcache_raddr_i (raddr),
        .dcache_rreq_i  (rreq),
        .dcache_waddr_i (waddr),
        .dcache_wdata_i (wdata),
        .dcache_wsel_i  (wsel),
        .dcache_wreq_i  (wreq),
        .dcache_data_o  (data_o),
        .dcache_stall_o (stall_o)
`ifdef DCACHE_RESP_STATS_EN
        ,
        .hit_cnt_o      (hit_cnt),
        .miss_cnt_o     (miss_cnt)
`endif
    );

    always #5 clk = ~clk;

    int          n_pass  = 0;
    int          n_total = 0;

    logic [31:0] arch  [1024];
    bit          aknown[1024];
    logic [31:0] back  [1024];
    bit          bknown[1024];
    bit          m_valid[16];
    bit          m_dirty[16];
    int          m_tag  [16];

    logic        chk_en    = 1'b0;
    logic        exp_stall = 1'b0;
    logic        chk_data  = 1'b0;
    logic [31:0] exp_data  = 32'h0;
    int          obs_stall;
    logic [31:0] last_data;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    // Bring a line in for address a; returns the number of stall cycles it costs.
    function automatic int model_fill(input logic [31:0] a);
        int idx, tg, c, w;
        idx = int'(a[7:4]);
        tg  = int'(a[11:8]);
        if (m_valid[idx] && m_tag[idx] == tg) return 0;
        c = 1 + L;
        if (m_valid[idx] && m_dirty[idx]) begin
            c += L;
            for (int k = 0; k < 4; k++) begin
                w = m_tag[idx] * 64 + idx * 4 + k;
                back[w]   = arch[w];
                bknown[w] = aknown[w];
            end
        end
        m_valid[idx] = 1'b1;
        m_dirty[idx] = 1'b0;
        m_tag[idx]   = tg;
        return c;
    endfunction

    function automatic void model_write(input logic [31:0] a, input logic [31:0] d,
                                        input logic [3:0] s);
        int w;
        w = int'(a[11:2]);
        for (int b = 0; b < 4; b++) begin
            if (s[b]) arch[w][8*b +: 8] = d[8*b +: 8];
        end
        if (s == 4'hF) aknown[w] = 1'b1;
        if (s != 4'h0) m_dirty[int'(a[7:4])] = 1'b1;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end
        for (int i = 0; i < 1024; i++) begin
            arch[i]   = back[i];
            aknown[i] = bknown[i];
        end
    endfunction

    // per-cycle comparison against the expectation the driver publishes
    always @(negedge clk) begin
        if (chk_en) begin
            check("stall", 32'(stall_o), 32'(exp_stall));
            if (!rreq) check("data_norreq", data_o, 32'h0);
            if (chk_data) check("rdata", data_o, exp_data);
        end
    end

    task automatic idle(input int n);
        rreq = 1'b0; wreq = 1'b0;
        chk_en = 1'b1; exp_stall = 1'b0; chk_data = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic reset_dut();
        chk_en = 1'b0; rreq = 1'b0; wreq = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
    endtask

    // Called just after a rising edge; holds the request until it completes.
    task automatic access(input logic rd, input logic [31:0] ra, input logic wr,
                          input logic [31:0] wa, input logic [31:0] wd, input logic [3:0] ws);
        int  total;
        bit  known;
        total = 0;
        if (wr) begin
            total += model_fill(wa);
            model_write(wa, wd, ws);
        end
        if (rd) total += model_fill(ra);
        known = rd && aknown[int'(ra[11:2])];
        exp_data = arch[int'(ra[11:2])];
        raddr = ra; rreq = rd; waddr = wa; wdata = wd; wsel = ws; wreq = wr;
        chk_en = 1'b1;
        obs_stall = 0;
        for (int i = 0; i <= total; i++) begin
            exp_stall = (i < total);
            chk_data  = known && (i == total);
            @(negedge clk);
            if (stall_o) obs_stall++;
            if (i == total) last_data = data_o;
            @(posedge clk); #1;
        end
        rreq = 1'b0; wreq = 1'b0; exp_stall = 1'b0; chk_data = 1'b0;
    endtask

    initial begin
        logic [31:0] ra, wa;
        logic        rd, wr;
        logic [3:0]  ws;

        rst = 1'b1; rreq = 1'b0; wreq = 1'b0;
        raddr = 32'h0; waddr = 32'h0; wdata = 32'h0; wsel = 4'h0;
        for (int i = 0; i < 1024; i++) begin
            arch[i] = 32'h0; back[i] = 32'h0; aknown[i] = 1'b0; bknown[i] = 1'b0;
        end
        for (int i = 0; i < 16; i++) m_tag[i] = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        idle(2);

        // make backing word 0x004 known, then read it from a cold cache
        access(0, 32'h0, 1, 32'h010, 32'hC0FFEE04, 4'hF);
        check("cold_write_stall", 32'(obs_stall), 32'd5);
        access(1, 32'h110, 0, 32'h0, 32'h0, 4'h0);
        check("dirty_evict_stall", 32'(obs_stall), 32'd9);
        reset_dut();
        access(1, 32'h010, 0, 32'h0, 32'h0, 4'h0);
        check("cold_read_stall", 32'(obs_stall), 32'd5);
        check("cold_read_data", last_data, 32'hC0FFEE04);

        // write then read-hit on the following cycle
        access(0, 32'h0, 1, 32'h020, 32'h0000BEEF, 4'hF);
        access(1, 32'h020, 0, 32'h0, 32'h0, 4'h0);
        check("rd_after_wr_stall", 32'(obs_stall), 32'd0);
        check("rd_after_wr_data", last_data, 32'h0000BEEF);

        // byte-enable merge, same-cycle forwarding and wsel=0
        access(0, 32'h0, 1, 32'h030, 32'h11223344, 4'hF);
        access(0, 32'h0, 1, 32'h030, 32'hAABBCCDD, 4'b0101);
        access(1, 32'h030, 0, 32'h0, 32'h0, 4'h0);
        check("merge_data", last_data, 32'h11BB33DD);
        access(0, 32'h0, 1, 32'h030, 32'h11223344, 4'hF);
        access(1, 32'h030, 1, 32'h030, 32'hAABBCCDD, 4'b0101);
        check("fwd_stall", 32'(obs_stall), 32'd0);
        check("fwd_data", last_data, 32'h11BB33DD);
        access(0, 32'h0, 1, 32'h030, 32'hFFFFFFFF, 4'h0);
        access(1, 32'h030, 0, 32'h0, 32'h0, 4'h0);
        check("wsel0_data", last_data, 32'h11BB33DD);
        access(1, 32'h060, 0, 32'h0, 32'h0, 4'h0);
        access(0, 32'h0, 1, 32'h060, 32'hFFFFFFFF, 4'h0);
        access(1, 32'h160, 0, 32'h0, 32'h0, 4'h0);
        check("wsel0_clean_stall", 32'(obs_stall), 32'd5);

        // dirty miss and writeback contents
        access(0, 32'h0, 1, 32'h040, 32'h44440040, 4'hF);
        access(1, 32'h140, 0, 32'h0, 32'h0, 4'h0);
        check("dirty_miss_stall", 32'(obs_stall), 32'd9);
        access(1, 32'h040, 0, 32'h0, 32'h0, 4'h0);
        check("wb_readback_stall", 32'(obs_stall), 32'd5);
        check("wb_readback_data", last_data, 32'h44440040);

        // reset during the second WB cycle must abandon the writeback
        access(0, 32'h0, 1, 32'h050, 32'h0BAD0050, 4'hF);
        access(1, 32'h150, 0, 32'h0, 32'h0, 4'h0);
        reset_dut();
        access(0, 32'h0, 1, 32'h050, 32'h55555555, 4'hF);
        chk_en = 1'b0;
        raddr = 32'h150; rreq = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1; rreq = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        idle(1);
        access(1, 32'h050, 0, 32'h0, 32'h0, 4'h0);
        check("rst_wb_stall", 32'(obs_stall), 32'd5);
        check("rst_wb_data", last_data, 32'h0BAD0050);

        // randomized traffic
        for (int n = 0; n < 350; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                idle($urandom_range(1, 3));
            end else if ($urandom_range(0, 40) == 0) begin
                reset_dut();
            end else begin
                rd = 1'($urandom_range(0, 1));
                wr = 1'($urandom_range(0, 1));
                if (!rd && !wr) rd = 1'b1;
                ra = $urandom(); ra[11:10] = 2'b00;
                wa = $urandom(); wa[11:10] = 2'b00;
                if ($urandom_range(0, 3) == 0) wa[11:2] = ra[11:2];
                if (rd && wr && wa[7:4] == ra[7:4] && wa[11:8] != ra[11:8]) wa[11:8] = ra[11:8];
                ws = ($urandom_range(0, 2) == 0) ? 4'($urandom()) : 4'hF;
                access(rd, ra, wr, wa, $urandom(), ws);
            end
        end

`ifdef DCACHE_RESP_STATS_EN
        reset_dut();
        access(1, 32'h700, 0, 32'h0, 32'h0, 4'h0);
        access(1, 32'h704, 0, 32'h0, 32'h0, 4'h0);
        access(1, 32'h708, 0, 32'h0, 32'h0, 4'h0);
        check("hit_cnt", hit_cnt, 32'd3);
        check("miss_cnt", miss_cnt, 32'd1);
`endif

        chk_en = 1'b0;
        idle(1);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
